// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's PC, I-cache and decode-side signals.
// Handshake: a fetch request transfers on a cycle where ic_req && ic_ready;
// ic_req, once raised, stays high with a stable ic_addr until that cycle.
// ic_rvalid is a single-cycle data strobe with no back-pressure. inst_valid
// is held with stable inst/inst_pc until a cycle with stall == 0 or a redirect.
interface fetch_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic [PC_W-1:0]   pc_cur;
    logic [PC_W-1:0]   pc_next;
    logic              pc_we;
    logic              ic_req;
    logic [PC_W-1:0]   ic_addr;
    logic              ic_ready;
    logic              ic_rvalid;
    logic [INST_W-1:0] ic_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic [1:0]        dbg_state;

    modport master (
        input  pc_cur, ic_ready, ic_rvalid, ic_rdata, stall, redirect_valid, redirect_pc,
        output pc_next, pc_we, ic_req, ic_addr, inst_valid, inst, inst_pc, dbg_state
    );

    modport slave (
        output pc_cur, ic_ready, ic_rvalid, ic_rdata, stall, redirect_valid, redirect_pc,
        input  pc_next, pc_we, ic_req, ic_addr, inst_valid, inst, inst_pc, dbg_state
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steps the external PC, issues one I-cache
// request at a time, registers returned instructions for decode and folds
// branch/trap redirects in without aborting an in-flight cache request.
module fetch_ctrl #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input logic        clk,
    input logic        rst,
    fetch_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              pend_q, pend_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;

    logic              pc_we_c;
    logic [PC_W-1:0]   pc_next_c;
    logic [PC_W-1:0]   pc_inc;

    assign pc_inc = bus.pc_cur + PC_W'(4);

    // Next-state and PC-update decisions for the four fetch states.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_we_c   = 1'b0;
        pc_next_c = pc_inc;
        case (state_q)
            S_IDLE: begin
                pc_we_c   = 1'b1;
                pc_next_c = bus.redirect_valid ? bus.redirect_pc : pc_inc;
                state_d   = S_REQ;
            end
            S_REQ: begin
                // A redirect cannot cancel the request, so remember it.
                if (bus.redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.redirect_pc;
                end
                if (bus.ic_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ic_rvalid) begin
                    if (bus.redirect_valid) begin
                        pc_we_c   = 1'b1;
                        pc_next_c = bus.redirect_pc;
                        pend_d    = 1'b0;
                        state_d   = S_REQ;
                    end else if (pend_q) begin
                        pc_we_c   = 1'b1;
                        pc_next_c = pend_pc_q;
                        pend_d    = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        inst_d    = bus.ic_rdata;
                        inst_pc_d = bus.pc_cur;
                        state_d   = S_ISSUE;
                    end
                end else if (bus.redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.redirect_pc;
                end
            end
            S_ISSUE: begin
                // A redirect wins over a stalled decode stage.
                if (bus.redirect_valid) begin
                    pc_we_c   = 1'b1;
                    pc_next_c = bus.redirect_pc;
                    state_d   = S_REQ;
                end else if (!bus.stall) begin
                    pc_we_c   = 1'b1;
                    pc_next_c = pc_inc;
                    state_d   = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-instruction registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // pc_we is qualified by rst so IDLE cannot write the PC while reset is held.
    assign bus.pc_we      = pc_we_c & rst;
    assign bus.pc_next    = {pc_next_c[PC_W-1:2], 2'b00};
    assign bus.ic_req     = (state_q == S_REQ);
    assign bus.ic_addr    = bus.pc_cur;
    assign bus.inst_valid = (state_q == S_ISSUE);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.dbg_state  = state_q;

endmodule
